fft_seq_ctrl: RTL and testbench

- Sequencer for the iterative radix-2 DIT FFT datapath: s_p → mux → butterfly → demux → reg2/p_s.
- Replaces the current flag-only ctrl. Each frame it walks all stages and issues one butterfly per cycle with operand addresses and twiddle index.
- Drives mux/demux select, delays write-back addresses to match butterfly latency, and hands the finished frame to p_s with a ready handshake.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_wb_delay.sv | 30 +++
 rtl/fft_seq_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the iterative radix-2 DIT FFT: default geometry, sequencer
// state encoding and the mux/demux select values used across the datapath.
package fft_pkg;

    localparam int FFT_N_LOG2 = 4;
    localparam int FFT_BF_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } fft_state_e;

    localparam logic MUX_SP  = 1'b0;
    localparam logic MUX_FB  = 1'b1;
    localparam logic DMX_REG = 1'b0;
    localparam logic DMX_PS  = 1'b1;

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth shift line that ages butterfly issue information until the
// matching butterfly result leaves the pipeline.
module fft_wb_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] line_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign q_o = line_q[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the iterative radix-2 DIT FFT: walks every stage, issues one
// butterfly per cycle, aligns write-back with the butterfly latency, hands off to p_s.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int BF_LAT = FFT_BF_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    input  logic              ps_ready,
    output logic              mux_flag,
    output logic              bf_en,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic [N_LOG2-2:0] rotation,
    output logic              wb_en,
    output logic [N_LOG2-1:0] wb_addr_a,
    output logic [N_LOG2-1:0] wb_addr_b,
    output logic              demux_flag,
    output logic              ps_load,
    output logic [2:0]        stage,
    output logic              busy,
    output logic              done,
    output logic              frame_drop
);

    localparam int              JW         = N_LOG2 - 1;
    localparam int              DW         = 2 + 2 * N_LOG2;
    localparam logic [JW-1:0]   J_LAST     = {JW{1'b1}};
    localparam logic [2:0]      LAST_STAGE = 3'(N_LOG2 - 1);
    localparam logic [2:0]      DRAIN_CNT  = 3'(BF_LAT);

    fft_state_e        state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [JW-1:0]     j_q, j_d;

    logic              issue;
    logic [2:0]        iss_stage;
    logic [JW-1:0]     iss_j;
    logic              ps_load_d, busy_d, done_d, drop_d, mux_d;

    logic [N_LOG2-1:0] jx_w, half_w, pos_w, grp_w, addr_a_w, addr_b_w;
    logic [JW-1:0]     rot_w;

    logic              bf_en_q, mux_q, dmx_tag_q, ps_load_q, busy_q, done_q, drop_q;
    logic [N_LOG2-1:0] addr_a_q, addr_b_q;
    logic [JW-1:0]     rot_q;

    logic              wb_clr;
    logic [DW-1:0]     wb_bus;

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        j_d       = j_q;
        cnt_d     = cnt_q;
        issue     = 1'b0;
        iss_stage = stage_q;
        iss_j     = j_q;
        ps_load_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        drop_d    = frame_valid && (state_q != ST_IDLE);
        mux_d     = mux_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    issue     = 1'b1;
                    iss_stage = 3'd0;
                    iss_j     = '0;
                    stage_d   = 3'd0;
                    j_d       = JW'(1);
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                if (j_q == J_LAST) begin
                    cnt_d   = DRAIN_CNT;
                    state_d = ST_DRAIN;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            ST_DRAIN: begin
                // Next stage only starts once every result of this stage is written back
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (stage_q == LAST_STAGE) begin
                    ps_load_d = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    issue     = 1'b1;
                    iss_stage = stage_q + 3'd1;
                    iss_j     = '0;
                    stage_d   = stage_q + 3'd1;
                    j_d       = JW'(1);
                    state_d   = ST_RUN;
                end
            end
            ST_OUT: begin
                if (ps_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ps_load_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            mux_d = (iss_stage != 3'd0) ? MUX_FB : MUX_SP;
        end
    end

    // Butterfly j of stage s pairs indices half apart inside groups of 2*half
    always_comb begin
        jx_w     = {1'b0, iss_j};
        half_w   = N_LOG2'(1) << iss_stage;
        pos_w    = jx_w & (half_w - N_LOG2'(1));
        grp_w    = jx_w >> iss_stage;
        addr_a_w = (grp_w << ({1'b0, iss_stage} + 4'd1)) + pos_w;
        addr_b_w = addr_a_w + half_w;
        rot_w    = JW'(pos_w << (3'(JW) - iss_stage));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            stage_q   <= 3'd0;
            cnt_q     <= 3'd0;
            j_q       <= '0;
            bf_en_q   <= 1'b0;
            mux_q     <= 1'b0;
            dmx_tag_q <= 1'b0;
            ps_load_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            rot_q     <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            j_q       <= j_d;
            bf_en_q   <= issue;
            mux_q     <= mux_d;
            dmx_tag_q <= (issue && iss_stage == LAST_STAGE) ? DMX_PS : DMX_REG;
            ps_load_q <= ps_load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
            if (issue) begin
                addr_a_q <= addr_a_w;
                addr_b_q <= addr_b_w;
                rot_q    <= rot_w;
            end
        end
    end

    assign wb_clr = ~rst_n;

    fft_wb_delay #(
        .DEPTH (BF_LAT),
        .W     (DW)
    ) u_wb_delay (
        .clk   (clk),
        .clr_i (wb_clr),
        .d_i   ({bf_en_q, dmx_tag_q, addr_a_q, addr_b_q}),
        .q_o   (wb_bus)
    );

    assign wb_en      = wb_bus[DW-1];
    assign demux_flag = wb_bus[DW-2];
    assign wb_addr_a  = wb_bus[2*N_LOG2-1:N_LOG2];
    assign wb_addr_b  = wb_bus[N_LOG2-1:0];

    assign mux_flag   = mux_q;
    assign bf_en      = bf_en_q;
    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign rotation   = rot_q;
    assign ps_load    = ps_load_q;
    assign stage      = stage_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_drop = drop_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: two configurations (N_LOG2=4/BF_LAT=2 and 3/1) share one
// stimulus; a frame-schedule model predicts every output on every cycle.
module tb_fft_seq_ctrl;

    localparam int MAXC = 128;
    localparam int OFF  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, frame_valid = 1'b0, ps_ready = 1'b1;

    logic       mux0, bf0, wb0, dmx0, ps0, busy0, done0, drop0;
    logic [3:0] a0, b0, wa0, wbb0;
    logic [2:0] rot0, stg0;
    logic       mux1, bf1, wb1, dmx1, ps1, busy1, done1, drop1;
    logic [2:0] a1, b1, wa1, wbb1;
    logic [1:0] rot1;
    logic [2:0] stg1;

    fft_seq_ctrl #(.N_LOG2(4), .BF_LAT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .ps_ready(ps_ready),
        .mux_flag(mux0), .bf_en(bf0), .addr_a(a0), .addr_b(b0), .rotation(rot0),
        .wb_en(wb0), .wb_addr_a(wa0), .wb_addr_b(wbb0), .demux_flag(dmx0),
        .ps_load(ps0), .stage(stg0), .busy(busy0), .done(done0), .frame_drop(drop0));

    fft_seq_ctrl #(.N_LOG2(3), .BF_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .ps_ready(ps_ready),
        .mux_flag(mux1), .bf_en(bf1), .addr_a(a1), .addr_b(b1), .rotation(rot1),
        .wb_en(wb1), .wb_addr_a(wa1), .wb_addr_b(wbb1), .demux_flag(dmx1),
        .ps_load(ps1), .stage(stg1), .busy(busy1), .done(done1), .frame_drop(drop1));

    bit s_fv [MAXC];
    bit s_rdy[MAXC];
    bit s_rst[MAXC];

    int e_bf[2][MAXC], e_a[2][MAXC], e_b[2][MAXC], e_rot[2][MAXC], e_mux[2][MAXC];
    int e_wb[2][MAXC], e_wa[2][MAXC], e_wbb[2][MAXC], e_dmx[2][MAXC], e_ps[2][MAXC];
    int e_stg[2][MAXC], e_busy[2][MAXC], e_done[2][MAXC], e_drop[2][MAXC];

    int nvec = 0;
    int nerr = 0;
    int cur  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input int cfg, input string nm, input int c, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL cfg%0d %s t=%0d: got %0d, expected %0d", cfg, nm, c - OFF, act, exp);
        end
    endtask

    task automatic clr_stim();
        for (int c = 0; c < MAXC; c++) begin
            s_fv[c]  = 1'b0;
            s_rdy[c] = 1'b1;
            s_rst[c] = (c >= OFF);
        end
    endtask

    // Frame schedule: issue at t0+1+s*(N/2+LAT)+j, then p_s hand-off until accepted.
    task automatic build(input int cfg, input int nl, input int lat, input int K);
        int  halfn, per, t0, e, s, j, hf, pos, n;
        bit  active, clean;
        halfn  = 1 << (nl - 1);
        per    = halfn + lat;
        active = 1'b0;
        t0     = 0;
        for (int c = 0; c < MAXC; c++) begin
            e_bf[cfg][c] = 0;  e_a[cfg][c] = 0;   e_b[cfg][c] = 0;    e_rot[cfg][c] = 0;
            e_mux[cfg][c] = 0; e_wb[cfg][c] = 0;  e_wa[cfg][c] = 0;   e_wbb[cfg][c] = 0;
            e_dmx[cfg][c] = 0; e_ps[cfg][c] = 0;  e_stg[cfg][c] = 0;  e_busy[cfg][c] = 0;
            e_done[cfg][c] = 0; e_drop[cfg][c] = 0;
        end
        for (int c = 0; c < K - 1; c++) begin
            n = c + 1;
            if (!s_rst[c]) begin
                active = 1'b0;
            end else begin
                e_mux[cfg][n]  = e_mux[cfg][c];
                e_stg[cfg][n]  = e_stg[cfg][c];
                e_drop[cfg][n] = (s_fv[c] && active) ? 1 : 0;
                if (active && e_ps[cfg][c] == 1 && s_rdy[c]) begin
                    e_done[cfg][n] = 1;
                    active = 1'b0;
                end else if (!active && s_fv[c]) begin
                    active = 1'b1;
                    t0 = c;
                end
                if (active) begin
                    e = c - t0;
                    e_busy[cfg][n] = 1;
                    if (e < nl * per) begin
                        s = e / per;
                        j = e % per;
                        e_stg[cfg][n] = s;
                        if (j < halfn) begin
                            hf  = 1 << s;
                            pos = j & (hf - 1);
                            e_bf[cfg][n]  = 1;
                            e_a[cfg][n]   = (j >> s) * 2 * hf + pos;
                            e_b[cfg][n]   = e_a[cfg][n] + hf;
                            e_rot[cfg][n] = pos << (nl - 1 - s);
                            e_mux[cfg][n] = (s != 0) ? 1 : 0;
                        end
                    end else begin
                        e_ps[cfg][n] = 1;
                    end
                end
            end
        end
        for (int c = lat; c < K; c++) begin
            clean = 1'b1;
            for (int k = c - lat; k < c; k++) if (!s_rst[k]) clean = 1'b0;
            if (clean && e_bf[cfg][c-lat] == 1) begin
                e_wb[cfg][c]  = 1;
                e_wa[cfg][c]  = e_a[cfg][c-lat];
                e_wbb[cfg][c] = e_b[cfg][c-lat];
                e_dmx[cfg][c] = (e_stg[cfg][c-lat] == nl - 1) ? 1 : 0;
            end
        end
    endtask

    task automatic cmp(input int cfg, input int c, input int bf, input int a, input int b,
                       input int rot, input int mux, input int wb, input int wa, input int wbb,
                       input int dmx, input int ps, input int stg, input int busy,
                       input int done, input int drop);
        chk(cfg, "bf_en", c, bf, e_bf[cfg][c]);
        if (e_bf[cfg][c] == 1) begin
            chk(cfg, "addr_a", c, a, e_a[cfg][c]);
            chk(cfg, "addr_b", c, b, e_b[cfg][c]);
            chk(cfg, "rotation", c, rot, e_rot[cfg][c]);
        end
        chk(cfg, "mux_flag", c, mux, e_mux[cfg][c]);
        chk(cfg, "wb_en", c, wb, e_wb[cfg][c]);
        if (e_wb[cfg][c] == 1) begin
            chk(cfg, "wb_addr_a", c, wa, e_wa[cfg][c]);
            chk(cfg, "wb_addr_b", c, wbb, e_wbb[cfg][c]);
        end
        chk(cfg, "demux_flag", c, dmx, e_dmx[cfg][c]);
        chk(cfg, "ps_load", c, ps, e_ps[cfg][c]);
        chk(cfg, "stage", c, stg, e_stg[cfg][c]);
        chk(cfg, "busy", c, busy, e_busy[cfg][c]);
        chk(cfg, "done", c, done, e_done[cfg][c]);
        chk(cfg, "frame_drop", c, drop, e_drop[cfg][c]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, cur, int'(bf0), int'(a0), int'(b0), int'(rot0), int'(mux0), int'(wb0),
                int'(wa0), int'(wbb0), int'(dmx0), int'(ps0), int'(stg0), int'(busy0),
                int'(done0), int'(drop0));
            cmp(1, cur, int'(bf1), int'(a1), int'(b1), int'(rot1), int'(mux1), int'(wb1),
                int'(wa1), int'(wbb1), int'(dmx1), int'(ps1), int'(stg1), int'(busy1),
                int'(done1), int'(drop1));
        end
    end

    task automatic run(input int K);
        for (int c = 0; c < K; c++) begin
            @(posedge clk);
            #1;
            cur         = c;
            rst_n       = s_rst[c];
            frame_valid = s_fv[c];
            ps_ready    = s_rdy[c];
            chk_en      = (c >= 1);
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;
    endtask

    task automatic prep(input int K);
        build(0, 4, 2, K);
        build(1, 3, 1, K);
    endtask

    initial begin
        // Single frame, ready held high
        clr_stim();
        s_fv[0+OFF] = 1'b1;
        prep(OFF + 50);
        chk(0, "pin bf t1", 1+OFF, e_bf[0][1+OFF], 1);
        chk(0, "pin bf t9", 9+OFF, e_bf[0][9+OFF], 0);
        chk(0, "pin a s0j3", 4+OFF, e_a[0][4+OFF], 6);
        chk(0, "pin b s0j3", 4+OFF, e_b[0][4+OFF], 7);
        chk(0, "pin a s2j5", 26+OFF, e_a[0][26+OFF], 9);
        chk(0, "pin b s2j5", 26+OFF, e_b[0][26+OFF], 13);
        chk(0, "pin rot s2j5", 26+OFF, e_rot[0][26+OFF], 2);
        chk(0, "pin a s3j7", 38+OFF, e_a[0][38+OFF], 7);
        chk(0, "pin b s3j7", 38+OFF, e_b[0][38+OFF], 15);
        chk(0, "pin rot s3j7", 38+OFF, e_rot[0][38+OFF], 7);
        chk(0, "pin mux t8", 8+OFF, e_mux[0][8+OFF], 0);
        chk(0, "pin mux t11", 11+OFF, e_mux[0][11+OFF], 1);
        chk(0, "pin wb t3", 3+OFF, e_wb[0][3+OFF], 1);
        chk(0, "pin dmx t32", 32+OFF, e_dmx[0][32+OFF], 0);
        chk(0, "pin dmx t33", 33+OFF, e_dmx[0][33+OFF], 1);
        chk(0, "pin ps t41", 41+OFF, e_ps[0][41+OFF], 1);
        chk(0, "pin busy t41", 41+OFF, e_busy[0][41+OFF], 1);
        chk(0, "pin busy t42", 42+OFF, e_busy[0][42+OFF], 0);
        chk(0, "pin done t42", 42+OFF, e_done[0][42+OFF], 1);
        chk(1, "pin a s1j3", 9+OFF, e_a[1][9+OFF], 5);
        chk(1, "pin b s1j3", 9+OFF, e_b[1][9+OFF], 7);
        chk(1, "pin rot s1j3", 9+OFF, e_rot[1][9+OFF], 2);
        chk(1, "pin done t17", 17+OFF, e_done[1][17+OFF], 1);
        run(OFF + 50);

        // Backpressure: p_s not ready until cycle 50
        clr_stim();
        s_fv[0+OFF] = 1'b1;
        for (int c = 0; c < 50 + OFF; c++) s_rdy[c] = 1'b0;
        prep(OFF + 60);
        chk(0, "pin ps t50", 50+OFF, e_ps[0][50+OFF], 1);
        chk(0, "pin done t42 bp", 42+OFF, e_done[0][42+OFF], 0);
        chk(0, "pin done t51", 51+OFF, e_done[0][51+OFF], 1);
        run(OFF + 60);

        // Overrun at 20, back-to-back frame on the done cycle
        clr_stim();
        s_fv[0+OFF]  = 1'b1;
        s_fv[20+OFF] = 1'b1;
        s_fv[42+OFF] = 1'b1;
        prep(OFF + 95);
        chk(0, "pin drop t21", 21+OFF, e_drop[0][21+OFF], 1);
        chk(0, "pin done t42 ov", 42+OFF, e_done[0][42+OFF], 1);
        chk(0, "pin bf t43", 43+OFF, e_bf[0][43+OFF], 1);
        run(OFF + 95);

        // Reset mid-frame, then a fresh frame
        clr_stim();
        s_fv[0+OFF]  = 1'b1;
        s_rst[15+OFF] = 1'b0;
        s_fv[25+OFF] = 1'b1;
        prep(OFF + 75);
        chk(0, "pin bf t16", 16+OFF, e_bf[0][16+OFF], 0);
        chk(0, "pin busy t16", 16+OFF, e_busy[0][16+OFF], 0);
        chk(0, "pin wb t17", 17+OFF, e_wb[0][17+OFF], 0);
        chk(0, "pin bf t26", 26+OFF, e_bf[0][26+OFF], 1);
        chk(0, "pin stage t26", 26+OFF, e_stg[0][26+OFF], 0);
        run(OFF + 75);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
